// File: rtl/add_seq3.sv
// Multi-cycle wide adder: adds two WIDTH-bit operands 3 bits per clock through one
// shared carry-select slice, with valid/ready handshakes on both sides.
module add_seq3 #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned N    = WIDTH / 3;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [2:0] chunk_a, chunk_b;
    logic [3:0] sel_sum0, sel_sum1;
    logic [2:0] slice_sum;
    logic       slice_co;
    logic       slice_c2;

    // Operand chunk selected by the current index.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (idx_q == IdxW'(k)) begin
                chunk_a = opa_q[3*k +: 3];
                chunk_b = opb_q[3*k +: 3];
            end
        end
    end

    // Carry-select slice: both carry-in cases are precomputed, the chained carry picks one.
    always_comb begin
        sel_sum0  = {1'b0, chunk_a} + {1'b0, chunk_b};
        sel_sum1  = {1'b0, chunk_a} + {1'b0, chunk_b} + 4'd1;
        slice_sum = carry_q ? sel_sum1[2:0] : sel_sum0[2:0];
        slice_co  = carry_q ? sel_sum1[3] : sel_sum0[3];
        slice_c2  = chunk_a[2] ^ chunk_b[2] ^ slice_sum[2];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    for (int unsigned k = 0; k < N; k++) begin
                        if (idx_q == IdxW'(k)) begin
                            sum_d[3*k +: 3] = slice_sum;
                        end
                    end
                    carry_d = slice_co;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IdxW'(N - 1)) begin
                        cout_d  = slice_co;
                        ovf_d   = slice_c2 ^ slice_co;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRun);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
